data_sram_axi_bridge: RTL and testbench

//  Responder for the EX-stage data-sram-like request port (req/wr/size/wstrb/addr/wdata, addr_ok/data_ok/rdata).

---
 rtl/data_sram_axi_bridge_pkg.sv | 32 +++
 rtl/data_sram_axi_bridge_if.sv | 42 ++++
 rtl/data_sram_axi_bridge.sv | 179 +++++++++++++++++
 tb/tb_data_sram_axi_bridge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared definitions for the data-sram to AXI bridge: FSM state encoding,
// AXI response/size codes and small decode helpers.
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_AR  = 3'd1,
        ST_RD_R   = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_WR_B   = 3'd4,
        ST_DONE   = 3'd5
    } bridge_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
    localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

    // SLVERR and DECERR both carry bit 1 set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge_if.sv
// Single-beat AXI bus between the bridge (master) and the core crossbar (slave).
interface data_sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arsize, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arsize, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awsize, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// Data-sram request port responder issuing one single-beat AXI read or write per request.
// Optional DSRAM_BRIDGE_RESP_ERR_EN adds data_sram_err_o flagging SLVERR/DECERR completions.
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_req_i,
    input  logic                data_sram_wr_i,
    input  logic [1:0]          data_sram_size_i,
    input  logic [DATA_W/8-1:0] data_sram_wstrb_i,
    input  logic [ADDR_W-1:0]   data_sram_addr_i,
    input  logic [DATA_W-1:0]   data_sram_wdata_i,
    output logic                data_sram_addr_ok_o,
    output logic                data_sram_data_ok_o,
    output logic [DATA_W-1:0]   data_sram_rdata_o,
`ifdef DSRAM_BRIDGE_RESP_ERR_EN
    output logic                data_sram_err_o,
`endif
    data_sram_axi_bridge_if.master axi
);

    bridge_state_e       state_r;
    logic                wr_r;
    logic [1:0]          size_r;
    logic [DATA_W/8-1:0] wstrb_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                data_ok_r;
    logic                arvalid_r;
    logic                rready_r;
    logic                awvalid_r;
    logic                wvalid_r;
    logic                bready_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic                addr_ok_s;
    logic                accept_s;
    logic                aw_fire_s;
    logic                w_fire_s;

    // addr_ok is held low during reset so no request is seen as accepted then.
    assign addr_ok_s = (state_r == ST_IDLE) & ~rst;
    assign accept_s  = data_sram_req_i & addr_ok_s;
    assign aw_fire_s = awvalid_r & axi.awready;
    assign w_fire_s  = wvalid_r & axi.wready;

    assign data_sram_addr_ok_o = addr_ok_s;
    assign data_sram_data_ok_o = data_ok_r;
    assign data_sram_rdata_o   = rdata_r;

    assign axi.araddr  = addr_r;
    assign axi.arsize  = axi_size(size_r);
    assign axi.arvalid = arvalid_r;
    assign axi.rready  = rready_r;
    assign axi.awaddr  = addr_r;
    assign axi.awsize  = axi_size(size_r);
    assign axi.awvalid = awvalid_r;
    assign axi.wdata   = wdata_r;
    assign axi.wstrb   = wstrb_r;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_r;
    assign axi.bready  = bready_r;

`ifdef DSRAM_BRIDGE_RESP_ERR_EN
    logic err_r;
    assign data_sram_err_o = err_r;

    // Error flag is raised only in the DONE cycle, alongside data_ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_r == ST_RD_R && axi.rvalid) begin
            err_r <= resp_is_err(axi.rresp);
        end else if (state_r == ST_WR_B && axi.bvalid) begin
            err_r <= resp_is_err(axi.bresp);
        end else begin
            err_r <= 1'b0;
        end
    end
`endif

    // Request FSM with registered handshake outputs and latched request payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wr_r      <= 1'b0;
            size_r    <= 2'd0;
            wstrb_r   <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            data_ok_r <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            data_ok_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        wr_r      <= data_sram_wr_i;
                        size_r    <= data_sram_size_i;
                        wstrb_r   <= data_sram_wstrb_i;
                        addr_r    <= data_sram_addr_i;
                        wdata_r   <= data_sram_wdata_i;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (data_sram_wr_i) begin
                            state_r   <= ST_WR_REQ;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_RD_AR;
                            arvalid_r <= 1'b1;
                        end
                    end
                end
                ST_RD_AR: begin
                    if (axi.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (axi.rvalid) begin
                        rready_r  <= 1'b0;
                        rdata_r   <= axi.rdata;
                        data_ok_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently; leave once both have handshaked.
                    if (aw_fire_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_fire_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r | aw_fire_s) & (w_done_r | w_fire_s)) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (axi.bvalid) begin
                        bready_r  <= 1'b0;
                        data_ok_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Bench for data_sram_axi_bridge: transaction-level model checked every cycle plus directed latency/protocol checks.
// Define DSRAM_BRIDGE_RESP_ERR_EN to also exercise data_sram_err_o.
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
`ifdef DSRAM_BRIDGE_RESP_ERR_EN
    logic        err;
`endif

    data_sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    data_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_sram_req_i     (req),
        .data_sram_wr_i      (wr),
        .data_sram_size_i    (size),
        .data_sram_wstrb_i   (wstrb),
        .data_sram_addr_i    (addr),
        .data_sram_wdata_i   (wdata),
        .data_sram_addr_ok_o (addr_ok),
        .data_sram_data_ok_o (data_ok),
        .data_sram_rdata_o   (rdata),
`ifdef DSRAM_BRIDGE_RESP_ERR_EN
        .data_sram_err_o     (err),
`endif
        .axi                 (axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AXI slave stub with per-channel ready/response delays
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] r_data = 32'd0;
    logic [1:0]  r_resp = 2'b00;
    logic [1:0]  b_resp = 2'b00;

    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0;
            axi.wready = 1'b0; axi.bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            #1;
            if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_lat); ar_cnt++; end
            else begin axi.arready = 1'b0; ar_cnt = 0; end
            if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_lat); aw_cnt++; end
            else begin axi.awready = 1'b0; aw_cnt = 0; end
            if (axi.wvalid) begin axi.wready = (w_cnt >= w_lat); w_cnt++; end
            else begin axi.wready = 1'b0; w_cnt = 0; end
            if (axi.rready) begin axi.rvalid = (r_cnt >= r_lat); r_cnt++; end
            else begin axi.rvalid = 1'b0; r_cnt = 0; end
            if (axi.bready) begin axi.bvalid = (b_cnt >= b_lat); b_cnt++; end
            else begin axi.bvalid = 1'b0; b_cnt = 0; end
            axi.rdata = axi.rvalid ? r_data : 32'd0;
            axi.rresp = axi.rvalid ? r_resp : 2'b00;
            axi.bresp = axi.bvalid ? b_resp : 2'b00;
        end
    end

    // ---------------- transaction model: one request in flight, per-channel progress flags
    logic        have_req = 1'b0, done_pend = 1'b0, exp_err = 1'b0;
    logic        cur_wr = 1'b0;
    logic [1:0]  cur_size = 2'd0;
    logic [3:0]  cur_wstrb = 4'd0;
    logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0, last_rdata = 32'd0;
    logic        ar_done = 1'b0, aw_done = 1'b0, w_done = 1'b0;
    int          accept_cyc = 0, done_cyc = 0, last_lat = 0, last_gap = 0;
    int          aw_hi = 0, w_hi = 0;
    logic [2:0]  last_arsize = 3'd7, last_awsize = 3'd7;

    always @(negedge clk) begin
        logic exp_aok, exp_dok, e_ar, e_r, e_aw, e_w, e_b;
        if (rst) begin
            have_req = 1'b0; done_pend = 1'b0; last_rdata = 32'd0; exp_err = 1'b0;
        end else begin
            exp_aok = !have_req;
            exp_dok = done_pend;
            chk("addr_ok", addr_ok, exp_aok);
            chk("data_ok", data_ok, exp_dok);
`ifdef DSRAM_BRIDGE_RESP_ERR_EN
            chk("err", err, exp_dok & exp_err);
`endif
            if (exp_dok) begin
                chk("rdata", rdata, last_rdata);
                done_cyc = cyc;
                last_lat = cyc - accept_cyc;
                have_req = 1'b0;
                done_pend = 1'b0;
            end
            e_ar = have_req && !done_pend && !cur_wr && !ar_done;
            e_r  = have_req && !done_pend && !cur_wr && ar_done;
            e_aw = have_req && !done_pend && cur_wr && !aw_done;
            e_w  = have_req && !done_pend && cur_wr && !w_done;
            e_b  = have_req && !done_pend && cur_wr && aw_done && w_done;
            chk("arvalid", axi.arvalid, e_ar);
            chk("rready", axi.rready, e_r);
            chk("awvalid", axi.awvalid, e_aw);
            chk("wvalid", axi.wvalid, e_w);
            chk("bready", axi.bready, e_b);
            if (e_ar) begin
                chk("araddr", axi.araddr, cur_addr);
                chk("arsize", axi.arsize, {1'b0, cur_size});
            end
            if (e_aw) begin
                chk("awaddr", axi.awaddr, cur_addr);
                chk("awsize", axi.awsize, {1'b0, cur_size});
                aw_hi++;
            end
            if (e_w) begin
                chk("wdata", axi.wdata, cur_wdata);
                chk("wstrb", axi.wstrb, cur_wstrb);
                chk("wlast", axi.wlast, 1'b1);
                w_hi++;
            end
            if (e_ar && axi.arready) begin ar_done = 1'b1; last_arsize = axi.arsize; end
            if (e_r && axi.rvalid) begin
                last_rdata = axi.rdata; exp_err = axi.rresp[1]; done_pend = 1'b1;
            end
            if (e_aw && axi.awready) begin aw_done = 1'b1; last_awsize = axi.awsize; end
            if (e_w && axi.wready) w_done = 1'b1;
            if (e_b && axi.bvalid) begin exp_err = axi.bresp[1]; done_pend = 1'b1; end
            if (req && exp_aok) begin
                have_req = 1'b1; cur_wr = wr; cur_size = size; cur_wstrb = wstrb;
                cur_addr = addr; cur_wdata = wdata;
                ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
                aw_hi = 0; w_hi = 0;
                accept_cyc = cyc;
                last_gap = cyc - done_cyc;
            end
        end
    end

    // ---------------- stimulus helpers
    logic [31:0] done_rdata = 32'd0;
    logic        done_err = 1'b0;

    task automatic set_req(input logic w, input logic [1:0] s, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] d);
        wr = w; size = s; wstrb = st; addr = a; wdata = d; req = 1'b1;
    endtask

    task automatic wait_accept(input bit drop);
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = addr_ok;
        end
        if (!got) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        if (drop) req = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = data_ok;
        end
        if (!got) chk("done_timeout", 1'b0, 1'b1);
        done_rdata = rdata;
`ifdef DSRAM_BRIDGE_RESP_ERR_EN
        done_err = err;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_addr_ok", addr_ok, 1'b0);
        chk("reset_data_ok", data_ok, 1'b0);
        chk("reset_arvalid", axi.arvalid, 1'b0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: word read, zero-wait fabric
        set_req(1'b0, 2'd2, 4'hF, 32'h1000_0004, 32'd0);
        r_data = 32'hDEAD_BEEF;
        wait_accept(1'b1);
        wait_done();
        chk("t1_latency", last_lat, 3);
        chk("t1_rdata", done_rdata, 32'hDEAD_BEEF);
        chk("t1_arsize", last_arsize, 3'd2);

        // 2: store byte, awready 3 cycles late, bvalid 2 cycles late
        aw_lat = 3; b_lat = 2;
        set_req(1'b1, 2'd0, 4'b0100, 32'h1000_0002, 32'h5A5A_5A5A);
        wait_accept(1'b1);
        wait_done();
        chk("t2_w_cycles", w_hi, 1);
        chk("t2_aw_cycles", aw_hi, 4);
        chk("t2_latency", last_lat, 8);
        chk("t2_awsize", last_awsize, 3'd0);
        chk("t2_rdata_kept", done_rdata, 32'hDEAD_BEEF);
        aw_lat = 0; b_lat = 0;

        // 3: back-to-back reads with req held high
        r_data = 32'h0BAD_F00D;
        set_req(1'b0, 2'd2, 4'hF, 32'h1000_0010, 32'd0);
        wait_accept(1'b0);
        addr = 32'h1000_0014;
        wait_done();
        wait_accept(1'b1);
        chk("t3_gap", last_gap, 1);
        wait_done();
        chk("t3_rdata", done_rdata, 32'h0BAD_F00D);

        // 4: AR and R backpressure
        ar_lat = 5; r_lat = 4; r_data = 32'h1234_5678;
        set_req(1'b0, 2'd1, 4'hF, 32'h2000_0008, 32'd0);
        wait_accept(1'b1);
        wait_done();
        chk("t4_latency", last_lat, 12);
        chk("t4_rdata", done_rdata, 32'h1234_5678);
        ar_lat = 0; r_lat = 0;

        // 5: reset while waiting for B
        b_lat = 20;
        set_req(1'b1, 2'd2, 4'hF, 32'h3000_0000, 32'hCAFE_0001);
        wait_accept(1'b1);
        for (int i = 0; i < 64 && !axi.bready; i++) @(negedge clk);
        chk("t5_in_wr_b", axi.bready, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_bready", axi.bready, 1'b0);
        chk("t5_rst_awvalid", axi.awvalid, 1'b0);
        chk("t5_rst_wvalid", axi.wvalid, 1'b0);
        chk("t5_rst_arvalid", axi.arvalid, 1'b0);
        chk("t5_rst_rready", axi.rready, 1'b0);
        chk("t5_rst_addr_ok", addr_ok, 1'b0);
        chk("t5_rst_data_ok", data_ok, 1'b0);
        chk("t5_rst_rdata", rdata, 32'd0);
        b_lat = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r_data = 32'h7777_1111;
        set_req(1'b0, 2'd2, 4'hF, 32'h3000_0004, 32'd0);
        wait_accept(1'b1);
        wait_done();
        chk("t5_post_latency", last_lat, 3);
        chk("t5_post_rdata", done_rdata, 32'h7777_1111);

`ifdef DSRAM_BRIDGE_RESP_ERR_EN
        // 6: error response reporting
        b_resp = 2'b10;
        set_req(1'b1, 2'd2, 4'hF, 32'h4000_0000, 32'h0000_00AA);
        wait_accept(1'b1);
        wait_done();
        chk("t6_write_err", done_err, 1'b1);
        b_resp = 2'b00; r_resp = 2'b00;
        set_req(1'b0, 2'd2, 4'hF, 32'h4000_0004, 32'd0);
        wait_accept(1'b1);
        wait_done();
        chk("t6_read_err", done_err, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
